// File: rtl/rr_hold_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_hold_arbiter
//  Purpose  : Registered round-robin arbiter with grant lock. The current
//             owner keeps the resource while it requests, for up to MAX_HOLD
//             consecutive cycles. Priority then rotates to the port after
//             the last winner.
//  Revision : 1.0  initial release
// ============================================================================
module rr_hold_arbiter #(
    parameter  int NUM_PORTS = 16,
    parameter  int MAX_HOLD  = 8,
    localparam int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [ID_W-1:0]      gnt_id_o,
    output logic                 busy_o,
    output logic                 expire_o
);

    // The hold counter must be able to represent MAX_HOLD itself.
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [ID_W-1:0]  owner_q;
    logic [ID_W-1:0]  last_q;
    logic [CNT_W-1:0] hold_cnt_q;

    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic             owner_req;
    logic             at_max;
    logic             arb_now;

    // Rotating search starting at the port after the last winner. The last
    // winner itself is visited last, so an expiring owner only wins again
    // when nobody else is requesting.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_w;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            idx_w = ID_W'(idx);
            if (!win_found && req_i[idx_w]) begin
                win_found = 1'b1;
                win_id    = idx_w;
            end
        end
    end

    // Release happens when the owner stops requesting or its budget is spent.
    // Arbitration runs every idle cycle and on every release cycle.
    always_comb begin
        owner_req = req_i[owner_q];
        at_max    = (hold_cnt_q == CNT_W'(MAX_HOLD));
        arb_now   = (state_q == ST_IDLE) || !owner_req || at_max;
    end

    // Ownership state machine; every output is registered here so that the
    // grant, its index, busy and expire all move on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            last_q     <= ID_W'(NUM_PORTS - 1);
            hold_cnt_q <= '0;
            gnt_o      <= '0;
            gnt_id_o   <= '0;
            busy_o     <= 1'b0;
            expire_o   <= 1'b0;
        end else begin
            // Pulse only when a still-requesting owner is forced out.
            expire_o <= (state_q == ST_OWN) && owner_req && at_max;
            if (arb_now) begin
                if (win_found) begin
                    state_q    <= ST_OWN;
                    owner_q    <= win_id;
                    last_q     <= win_id;
                    hold_cnt_q <= CNT_W'(1);
                    gnt_o      <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << win_id;
                    gnt_id_o   <= win_id;
                    busy_o     <= 1'b1;
                end else begin
                    state_q    <= ST_IDLE;
                    hold_cnt_q <= '0;
                    gnt_o      <= '0;
                    gnt_id_o   <= '0;
                    busy_o     <= 1'b0;
                end
            end else begin
                hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
